// File: rtl/cern_be_arbiter.sv
`default_nettype none
// ============================================================================
// cern_be_arbiter : shares one CERN-BE slave port between two masters,
//                   round-robin, one access in flight, with a Done watchdog.
// Rev 1.0
// ============================================================================
module cern_be_arbiter #(
    parameter int AW      = 3,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic [AW:2]   m0_VMEAddr,
    input  logic [DW-1:0] m0_VMEWrData,
    input  logic          m0_VMERdMem,
    input  logic          m0_VMEWrMem,
    output logic [DW-1:0] m0_VMERdData,
    output logic          m0_VMERdDone,
    output logic          m0_VMEWrDone,
    output logic          m0_err,
    input  logic [AW:2]   m1_VMEAddr,
    input  logic [DW-1:0] m1_VMEWrData,
    input  logic          m1_VMERdMem,
    input  logic          m1_VMEWrMem,
    output logic [DW-1:0] m1_VMERdData,
    output logic          m1_VMERdDone,
    output logic          m1_VMEWrDone,
    output logic          m1_err,
    output logic [AW:2]   s_VMEAddr_o,
    output logic [DW-1:0] s_VMEWrData_o,
    output logic          s_VMERdMem_o,
    output logic          s_VMEWrMem_o,
    input  logic [DW-1:0] s_VMERdData_i,
    input  logic          s_VMERdDone_i,
    input  logic          s_VMEWrDone_i
);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ISSUE  = 2'd1;
    localparam logic [1:0]  S_WAIT   = 2'd2;
    localparam logic [1:0]  S_RESP   = 2'd3;
    localparam logic [15:0] WD_LIMIT = TIMEOUT[15:0];

    logic [1:0]          rd_stb, wr_stb, any_stb, take, drop;
    logic [1:0][AW:2]    in_addr, req_addr;
    logic [1:0][DW-1:0]  in_wdata, req_wdata, rdata;
    logic [1:0]          req_wr, pend, rd_done, wr_done, err;
    logic [1:0]          state;
    logic                last_grant, grant, owner, cur_wr, done_ok;
    logic [15:0]         wd;

    assign rd_stb   = {m1_VMERdMem, m0_VMERdMem};
    assign wr_stb   = {m1_VMEWrMem, m0_VMEWrMem};
    assign in_addr  = {m1_VMEAddr, m0_VMEAddr};
    assign in_wdata = {m1_VMEWrData, m0_VMEWrData};

    // pend stays set through RESP, so it also covers "in service"
    assign any_stb = rd_stb | wr_stb;
    assign take    = any_stb & ~pend;
    assign drop    = (any_stb & pend) | (rd_stb & wr_stb);
    assign grant   = (&pend) ? ~last_grant : pend[1];
    assign done_ok = cur_wr ? s_VMEWrDone_i : s_VMERdDone_i;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pend          <= '0;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            cur_wr        <= 1'b0;
            wd            <= '0;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_wr        <= '0;
            s_VMEAddr_o   <= '0;
            s_VMEWrData_o <= '0;
            s_VMERdMem_o  <= 1'b0;
            s_VMEWrMem_o  <= 1'b0;
            rd_done       <= '0;
            wr_done       <= '0;
            err           <= '0;
            rdata         <= '0;
        end else begin
            s_VMERdMem_o <= 1'b0;
            s_VMEWrMem_o <= 1'b0;
            rd_done      <= '0;
            wr_done      <= '0;
            err          <= drop;

            for (int m = 0; m < 2; m++) begin
                if (take[m]) begin
                    pend[m]      <= 1'b1;
                    req_addr[m]  <= in_addr[m];
                    req_wdata[m] <= in_wdata[m];
                    req_wr[m]    <= ~rd_stb[m];
                end
            end

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        owner         <= grant;
                        cur_wr        <= req_wr[grant];
                        s_VMEAddr_o   <= req_addr[grant];
                        s_VMEWrData_o <= req_wdata[grant];
                        s_VMERdMem_o  <= ~req_wr[grant];
                        s_VMEWrMem_o  <= req_wr[grant];
                        wd            <= '0;
                        state         <= S_ISSUE;
                    end
                end
                // master-side pulses are registered here so they appear in RESP
                S_ISSUE, S_WAIT: begin
                    state <= S_WAIT;
                    if (done_ok) begin
                        state          <= S_RESP;
                        rd_done[owner] <= ~cur_wr;
                        wr_done[owner] <= cur_wr;
                        if (!cur_wr) rdata[owner] <= s_VMERdData_i;
                    end else if (wd == WD_LIMIT) begin
                        state          <= S_RESP;
                        rd_done[owner] <= ~cur_wr;
                        wr_done[owner] <= cur_wr;
                        err[owner]     <= 1'b1;
                        if (!cur_wr) rdata[owner] <= '0;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                S_RESP: begin
                    pend[owner] <= 1'b0;
                    last_grant  <= owner;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m0_VMERdData = rdata[0];
    assign m0_VMERdDone = rd_done[0];
    assign m0_VMEWrDone = wr_done[0];
    assign m0_err       = err[0];
    assign m1_VMERdData = rdata[1];
    assign m1_VMERdDone = rd_done[1];
    assign m1_VMEWrDone = wr_done[1];
    assign m1_err       = err[1];
endmodule
`default_nettype wire

// File: tb/tb_cern_be_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cern_be_arbiter : table vectors, directed corner sequences and random
//                      traffic checked against a schedule-based reference model.
// Rev 1.0
// ============================================================================
module tb_cern_be_arbiter;
    localparam int TMO   = 16;
    localparam int STALL = 1000;

    logic             Clk = 1'b0;
    logic             rst_n;
    logic [1:0]       rdmem, wrmem;
    logic [1:0][1:0]  addr_in;
    logic [1:0][31:0] wd_in;
    wire  [1:0]       rd_done, wr_done, err;
    wire  [1:0][31:0] rdata;
    wire  [1:0]       s_addr;
    wire  [31:0]      s_wd;
    wire              s_rd, s_wr;
    logic [31:0]      s_rdata;
    logic             s_rd_done, s_wr_done;

    cern_be_arbiter #(.AW(3), .DW(32), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .m0_VMEAddr(addr_in[0]), .m0_VMEWrData(wd_in[0]),
        .m0_VMERdMem(rdmem[0]), .m0_VMEWrMem(wrmem[0]),
        .m0_VMERdData(rdata[0]), .m0_VMERdDone(rd_done[0]),
        .m0_VMEWrDone(wr_done[0]), .m0_err(err[0]),
        .m1_VMEAddr(addr_in[1]), .m1_VMEWrData(wd_in[1]),
        .m1_VMERdMem(rdmem[1]), .m1_VMEWrMem(wrmem[1]),
        .m1_VMERdData(rdata[1]), .m1_VMERdDone(rd_done[1]),
        .m1_VMEWrDone(wr_done[1]), .m1_err(err[1]),
        .s_VMEAddr_o(s_addr), .s_VMEWrData_o(s_wd),
        .s_VMERdMem_o(s_rd), .s_VMEWrMem_o(s_wr),
        .s_VMERdData_i(s_rdata), .s_VMERdDone_i(s_rd_done),
        .s_VMEWrDone_i(s_wr_done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every access is a scheduled window (grant, issue, response)
    int          c = 0;
    bit          mp[2];
    bit          p_wr[2];
    logic [1:0]  p_addr[2];
    logic [31:0] p_wd[2];
    int          last = 1, free_at = 0, issue_at = -1, resp_at = -1, sdone_at = -1, owner = 0;
    bit          o_wr = 1'b0, tmo = 1'b0;
    logic [31:0] o_sdata = '0;
    logic [1:0]  e_rd, e_wr, e_err;
    logic [31:0] e_rdata[2];
    bit          e_srd, e_swr;
    logic [1:0]  e_saddr;
    logic [31:0] e_swd;

    int          forced_lat = -1;
    bit          use_sdata = 1'b0, noise_en = 1'b0, late_wr = 1'b0;
    logic [31:0] forced_sdata = '0;
    int          done_log[$];
    int          s_count = 0, s_cycle = 0, d_cycle = 0;
    logic [1:0]  last_s_addr = '0;
    logic [1:0]  err_seen = '0;

    typedef struct {
        int m; bit rd; bit wr; logic [1:0] addr; logic [31:0] wd;
        int lat; logic [31:0] sdata; int exp_lat; logic [31:0] exp_rdata; bit exp_err;
    } vec_t;
    vec_t vecs[7];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = 1'b0; e_rdata[m] = '0;
        end
        last = 1; free_at = c; issue_at = -1; resp_at = -1; sdone_at = -1;
        e_rd = '0; e_wr = '0; e_err = '0; e_srd = 1'b0; e_swr = 1'b0;
        e_saddr = '0; e_swd = '0;
    endfunction

    function automatic void model_edge();
        logic [1:0] drop, take;
        int g, lat;
        for (int m = 0; m < 2; m++) begin
            take[m] = (rdmem[m] | wrmem[m]) & ~mp[m];
            drop[m] = ((rdmem[m] | wrmem[m]) & mp[m]) | (rdmem[m] & wrmem[m]);
        end
        if (c >= free_at && (mp[0] || mp[1])) begin
            g = (mp[0] && mp[1]) ? 1 - last : (mp[1] ? 1 : 0);
            owner = g; o_wr = p_wr[g]; issue_at = c + 1;
            if (forced_lat >= 0) lat = forced_lat;
            else lat = ($urandom_range(0, 15) == 0) ? STALL : int'($urandom_range(0, 3));
            o_sdata = use_sdata ? forced_sdata : $urandom();
            if (lat == STALL) begin
                tmo = 1'b1; sdone_at = -1; resp_at = c + 2 + TMO;
            end else begin
                tmo = 1'b0; sdone_at = c + 1 + lat; resp_at = c + 2 + lat;
            end
            free_at = resp_at + 1;
            e_saddr = p_addr[g]; e_swd = p_wd[g];
        end
        if (resp_at == c) begin
            mp[owner] = 1'b0; last = owner;
        end
        for (int m = 0; m < 2; m++) begin
            if (take[m]) begin
                mp[m] = 1'b1; p_addr[m] = addr_in[m]; p_wd[m] = wd_in[m]; p_wr[m] = ~rdmem[m];
            end
        end
        e_srd = (issue_at == c + 1) && !o_wr;
        e_swr = (issue_at == c + 1) && o_wr;
        for (int m = 0; m < 2; m++) begin
            e_rd[m]  = (resp_at == c + 1) && (owner == m) && !o_wr;
            e_wr[m]  = (resp_at == c + 1) && (owner == m) && o_wr;
            e_err[m] = drop[m] | ((resp_at == c + 1) && (owner == m) && tmo);
        end
        if (resp_at == c + 1 && !o_wr) e_rdata[owner] = tmo ? 32'h0 : o_sdata;
    endfunction

    task automatic drive_slave();
        bit win;
        win = (c >= issue_at) && (c < resp_at);
        s_rd_done = 1'b0; s_wr_done = 1'b0; s_rdata = $urandom();
        if (c == sdone_at) begin
            if (o_wr) s_wr_done = 1'b1;
            else begin s_rd_done = 1'b1; s_rdata = o_sdata; end
        end else if (noise_en) begin
            if (win) begin
                if (o_wr) s_rd_done = ($urandom_range(0, 3) == 0);
                else      s_wr_done = ($urandom_range(0, 3) == 0);
            end else begin
                s_rd_done = ($urandom_range(0, 3) == 0);
                s_wr_done = ($urandom_range(0, 3) == 0);
            end
        end
        if (late_wr) s_wr_done = 1'b1;
    endtask

    task automatic check_outputs();
        chk("rd_done",   64'(rd_done),  64'(e_rd));
        chk("wr_done",   64'(wr_done),  64'(e_wr));
        chk("err",       64'(err),      64'(e_err));
        chk("m0_rdata",  64'(rdata[0]), 64'(e_rdata[0]));
        chk("m1_rdata",  64'(rdata[1]), 64'(e_rdata[1]));
        chk("s_rdmem",   64'(s_rd),     64'(e_srd));
        chk("s_wrmem",   64'(s_wr),     64'(e_swr));
        chk("s_addr",    64'(s_addr),   64'(e_saddr));
        chk("s_wrdata",  64'(s_wd),     64'(e_swd));
    endtask

    task automatic tick();
        drive_slave();
        model_edge();
        @(posedge Clk); #1;
        c++;
        rdmem = '0; wrmem = '0; late_wr = 1'b0;
        err_seen |= err;
        for (int m = 0; m < 2; m++)
            if (rd_done[m] || wr_done[m]) begin done_log.push_back(m); d_cycle = c; end
        if (s_rd || s_wr) begin s_count++; s_cycle = c; last_s_addr = s_addr; end
        check_outputs();
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0; rdmem = '0; wrmem = '0; s_rd_done = 1'b0; s_wr_done = 1'b0;
        #1;
        chk("reset ctrl", 64'({rd_done, wr_done, err, s_rd, s_wr, s_addr}), 64'h0);
        chk("reset m0_rdata", 64'(rdata[0]), 64'h0);
        chk("reset m1_rdata", 64'(rdata[1]), 64'h0);
        chk("reset s_wrdata", 64'(s_wd), 64'h0);
        repeat (hold) @(posedge Clk);
        #1;
        rst_n = 1'b1;
        c += hold;
        model_reset();
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int k = 0; k < budget && done_log.size() < n; k++) tick();
        chk("done count", 64'(done_log.size()), 64'(n));
    endtask

    task automatic run_vec(input vec_t v);
        int got; bit got_rd; logic [31:0] got_data;
        got = -1; got_rd = 1'b0; got_data = '0; err_seen = '0;
        forced_lat = v.lat; use_sdata = 1'b1; forced_sdata = v.sdata;
        addr_in[v.m] = v.addr; wd_in[v.m] = v.wd; rdmem[v.m] = v.rd; wrmem[v.m] = v.wr;
        for (int k = 1; k <= 40 && got < 0; k++) begin
            tick();
            if (rd_done[v.m] || wr_done[v.m]) begin
                got = k; got_rd = rd_done[v.m]; got_data = rdata[v.m];
            end
        end
        chk("vec latency",   64'(got),           64'(v.exp_lat));
        chk("vec done type", 64'(got_rd),        64'(v.rd));
        if (v.rd) chk("vec rdata", 64'(got_data), 64'(v.exp_rdata));
        chk("vec err",       64'(err_seen[v.m]), 64'(v.exp_err));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; rdmem = '0; wrmem = '0; addr_in = '0; wd_in = '0;
        s_rd_done = 1'b0; s_wr_done = 1'b0; s_rdata = '0;
        @(posedge Clk); #1;
        do_reset(2);

        vecs[0] = '{0, 1'b1, 1'b0, 2'd1, 32'h0,        0,     32'hCAFE0001, 3,  32'hCAFE0001, 1'b0};
        vecs[1] = '{1, 1'b0, 1'b1, 2'd3, 32'h12345678, 2,     32'h0,        5,  32'h0,        1'b0};
        vecs[2] = '{0, 1'b1, 1'b1, 2'd2, 32'h0,        1,     32'hA5A50002, 4,  32'hA5A50002, 1'b1};
        vecs[3] = '{1, 1'b1, 1'b0, 2'd0, 32'h0,        3,     32'hDEADBEEF, 6,  32'hDEADBEEF, 1'b0};
        vecs[4] = '{1, 1'b0, 1'b1, 2'd1, 32'h77,       STALL, 32'h0,        19, 32'h0,        1'b1};
        vecs[5] = '{0, 1'b1, 1'b0, 2'd3, 32'h0,        STALL, 32'hFFFFFFFF, 19, 32'h0,        1'b1};
        vecs[6] = '{0, 1'b0, 1'b1, 2'd2, 32'h9,        1,     32'h0,        4,  32'h0,        1'b0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // simultaneous pair after reset, then rotation after a lone m0 access
        do_reset(1);
        forced_lat = 1; use_sdata = 1'b0;
        done_log.delete();
        wrmem[0] = 1'b1; rdmem[1] = 1'b1; tick();
        wait_dones(2, 30); tick();
        chk("pair1 first",  64'(done_log[0]), 64'd0);
        chk("pair1 second", 64'(done_log[1]), 64'd1);
        done_log.delete();
        rdmem[0] = 1'b1; tick();
        wait_dones(1, 20); tick();
        done_log.delete();
        wrmem[0] = 1'b1; rdmem[1] = 1'b1; tick();
        wait_dones(2, 30); tick();
        chk("pair2 first",  64'(done_log[0]), 64'd1);
        chk("pair2 second", 64'(done_log[1]), 64'd0);

        // second strobe while the first is still pending
        done_log.delete(); s_count = 0; err_seen = '0;
        rdmem[0] = 1'b1; addr_in[0] = 2'd1; tick();
        rdmem[0] = 1'b1; addr_in[0] = 2'd3; tick();
        wait_dones(1, 20); tick(); tick();
        chk("dup strobe err",   64'(err_seen[0]), 64'd1);
        chk("dup slave count",  64'(s_count),     64'd1);
        chk("dup slave addr",   64'(last_s_addr), 64'd1);

        // watchdog on a stalled write, then a late Done
        forced_lat = STALL; done_log.delete();
        wrmem[1] = 1'b1; addr_in[1] = 2'd3; wd_in[1] = 32'h5A5A0003; tick();
        wait_dones(1, 40);
        chk("timeout gap", 64'(d_cycle - s_cycle), 64'd17);
        late_wr = 1'b1; tick();
        late_wr = 1'b1; tick();
        tick();
        chk("late done ignored", 64'(done_log.size()), 64'd1);

        // reset while a m1 read waits on the slave
        done_log.delete();
        rdmem[1] = 1'b1; addr_in[1] = 2'd2; tick();
        repeat (6) tick();
        do_reset(2);
        repeat (20) tick();
        chk("no done after reset", 64'(done_log.size()), 64'd0);
        forced_lat = 0; use_sdata = 1'b1; forced_sdata = 32'h0BADF00D;
        rdmem[0] = 1'b1; addr_in[0] = 2'd1; tick();
        wait_dones(1, 20);
        chk("post-reset rdata", 64'(rdata[0]), 64'h0BADF00D);
        tick();

        // random traffic with stray slave Done noise
        noise_en = 1'b1; forced_lat = -1; use_sdata = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                int r;
                r = int'($urandom_range(0, 11));
                addr_in[m] = 2'($urandom());
                wd_in[m]   = $urandom();
                rdmem[m]   = (r == 0) || (r == 2);
                wrmem[m]   = (r == 1) || (r == 2);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
